// File: rtl/dmem_access_ctrl.sv
// Initiator-side controller for the multi-cycle data memory: one rd/wr pulse per
// held pipeline request, stall until mem_ready. Define DMEM_TIMEOUT_EN for the watchdog.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              timeout_c;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_err_q, resp_err_d;

  // Watchdog: cleared while issuing, counts WAIT cycles without mem_ready.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if ((state_q == WAIT) && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A ready arriving in the expiry cycle takes precedence over the abort.
  assign timeout_c  = (state_q == WAIT) && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign resp_err_d = timeout_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;
`else
  assign timeout_c = 1'b0;
  assign resp_err  = 1'b0;

  // Without the watchdog TIMEOUT has no effect on the hardware.
  if (TIMEOUT == 0) begin : g_no_watchdog
  end
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Next state; registered outputs are computed one cycle ahead of the state they belong to.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    mem_rd_en_d  = 1'b0;
    mem_wr_en_d  = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          mem_rd_en_d = !req_we;
          mem_wr_en_d = req_we;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : mem_rdata;
          state_d      = DONE;
        end else if (timeout_c) begin
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall = ((state_q == IDLE) && req_valid) || (state_q == ISSUE) || (state_q == WAIT);

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a latency-programmable memory model.
// Timeout scenarios run only when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  // Memory model: ready lat cycles after the pulse cycle (lat = 0 never readies).
  int          cyc = 0;
  int          lat = 1;
  int          inject_cyc = -1;
  int          pend = 0;
  logic        pend_rd;
  logic [31:0] pend_addr;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, dirty_cnt = 0;
  int          last_pulse_cyc = 0, prev_pulse_cyc = 0;
  logic [31:0] last_addr, last_wdata;
  logic [31:0] mem [0:255];

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (inject_cyc == cyc) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_ready = 1'b1;
          mem_rdata = pend_rd ? mem[pend_addr[7:0]] : '0;
        end
      end
      if (mem_rd_en && mem_wr_en) both_cnt++;
      if (mem_rd_en || mem_wr_en) begin
        prev_pulse_cyc = last_pulse_cyc;
        last_pulse_cyc = cyc;
        last_addr      = mem_addr;
        last_wdata     = mem_wdata;
        pend           = lat;
        pend_rd        = mem_rd_en;
        pend_addr      = mem_addr;
        if (mem_wr_en) begin
          wr_cnt++;
          mem[mem_addr[7:0]] = mem_wdata;
        end else begin
          rd_cnt++;
        end
      end else if ((mem_addr != '0) || (mem_wdata != '0)) begin
        dirty_cnt++;
      end
    end
  end

  // Waits (bounded) for resp_valid, counting stall cycles; starts sampling this cycle.
  task automatic wait_resp(output bit got, output logic [31:0] rdata, output logic err,
                           output int stalls);
    got    = 1'b0;
    rdata  = '0;
    err    = 1'b0;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (resp_valid === 1'b1) begin
        got   = 1'b1;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
      if (stall === 1'b1) stalls++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output bit got, output logic [31:0] rdata, output logic err,
                        output int stalls);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    wait_resp(got, rdata, err, stalls);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_rd_en, mem_wr_en} !== 2'b00)
      $display("FAIL reset_pulses got %b want 00", {mem_rd_en, mem_wr_en});
    else passed++;
    checks++;
    if ({mem_addr, mem_wdata} !== 64'd0)
      $display("FAIL reset_bus got %h want 0", {mem_addr, mem_wdata});
    else passed++;
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0)
      $display("FAIL reset_resp got %h want 0", {resp_valid, resp_err, resp_rdata});
    else passed++;
    checks++;
    if (stall !== 1'b0) $display("FAIL reset_stall_lo got %b want 0", stall);
    else passed++;
    req_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) $display("FAIL reset_stall_hi got %b want 1", stall);
    else passed++;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_store;
    bit got; logic [31:0] rd; logic err; int st; int r0, w0;
    lat = 30;
    r0 = rd_cnt;
    w0 = wr_cnt;
    run_op(1'b1, 32'h45, 32'h123, got, rd, err, st);
    checks++;
    if (!got) $display("FAIL store_resp got none want resp_valid");
    else passed++;
    checks++;
    if (st !== 32) $display("FAIL store_stall_cycles got %0d want 32", st);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL store_err got %b want 0", err);
    else passed++;
    checks++;
    if (rd !== 32'd0) $display("FAIL store_rdata got %h want 0", rd);
    else passed++;
    checks++;
    if ((wr_cnt - w0) !== 1 || (rd_cnt - r0) !== 0)
      $display("FAIL store_pulses got wr %0d rd %0d want wr 1 rd 0", wr_cnt - w0, rd_cnt - r0);
    else passed++;
    checks++;
    if (last_addr !== 32'h45 || last_wdata !== 32'h123)
      $display("FAIL store_bus got %h/%h want 45/123", last_addr, last_wdata);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) $display("FAIL store_resp_width got %b want 0", resp_valid);
    else passed++;
  endtask

  task automatic test_load_back;
    bit got; logic [31:0] rd; logic err; int st; int r0, w0;
    lat = 30;
    r0 = rd_cnt;
    w0 = wr_cnt;
    run_op(1'b0, 32'h45, 32'h0, got, rd, err, st);
    checks++;
    if (!got || rd !== 32'h123)
      $display("FAIL load_rdata got %h (resp %b) want 00000123", rd, got);
    else passed++;
    checks++;
    if (st !== 32) $display("FAIL load_stall_cycles got %0d want 32", st);
    else passed++;
    checks++;
    if ((rd_cnt - r0) !== 1 || (wr_cnt - w0) !== 0)
      $display("FAIL load_pulses got rd %0d wr %0d want rd 1 wr 0", rd_cnt - r0, wr_cnt - w0);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL load_err got %b want 0", err);
    else passed++;
  endtask

  task automatic test_back_to_back;
    bit got; logic [31:0] rd; logic err; int st; int r0;
    logic [31:0] rd_a, rd_b;
    bit got_a, got_b;
    lat = 3;
    run_op(1'b1, 32'h10, 32'hA5A5_0010, got, rd, err, st);
    run_op(1'b1, 32'h20, 32'h5A5A_0020, got, rd, err, st);
    lat = 1;
    r0 = rd_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    wait_resp(got_a, rd_a, err, st);
    req_addr = 32'h20;
    @(negedge clk);
    wait_resp(got_b, rd_b, err, st);
    req_valid = 1'b0;
    checks++;
    if (!got_a || rd_a !== 32'hA5A5_0010)
      $display("FAIL b2b_first got %h (resp %b) want a5a50010", rd_a, got_a);
    else passed++;
    checks++;
    if (!got_b || rd_b !== 32'h5A5A_0020)
      $display("FAIL b2b_second got %h (resp %b) want 5a5a0020", rd_b, got_b);
    else passed++;
    checks++;
    if ((rd_cnt - r0) !== 2) $display("FAIL b2b_pulses got %0d want 2", rd_cnt - r0);
    else passed++;
    checks++;
    if ((last_pulse_cyc - prev_pulse_cyc) !== 4)
      $display("FAIL b2b_spacing got %0d want 4", last_pulse_cyc - prev_pulse_cyc);
    else passed++;
    // Spurious ready while idle must not produce a response or a pulse.
    r0 = rd_cnt;
    @(negedge clk);
    inject_cyc = cyc + 1;
    @(negedge clk);
    #1;
    checks++;
    if ({stall, resp_valid} !== 2'b00)
      $display("FAIL spurious_idle got stall %b resp %b want 0 0", stall, resp_valid);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || (rd_cnt - r0) !== 0 || mem_wr_en !== 1'b0)
      $display("FAIL spurious_after got resp %b pulses %0d want 0 0", resp_valid, rd_cnt - r0);
    else passed++;
  endtask

  task automatic test_reset_mid_wait;
    int r0, w0, resp_seen, stall_seen;
    lat = 30;
    r0 = rd_cnt;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h45;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1) $display("FAIL rst_mid_pre_stall got %b want 1", stall);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1) $display("FAIL rst_mid_stall_req got %b want 1", stall);
    else passed++;
    checks++;
    if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata} !== 66'd0 || resp_valid !== 1'b0)
      $display("FAIL rst_mid_outputs got rd %b wr %b addr %h resp %b want all 0",
               mem_rd_en, mem_wr_en, mem_addr, resp_valid);
    else passed++;
    req_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) $display("FAIL rst_mid_stall_idle got %b want 0", stall);
    else passed++;
    @(negedge clk);
    reset      = 1'b0;
    resp_seen  = 0;
    stall_seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (resp_valid === 1'b1) resp_seen++;
      if (stall === 1'b1) stall_seen++;
    end
    checks++;
    if (resp_seen !== 0 || stall_seen !== 0)
      $display("FAIL rst_mid_quiet got resp %0d stall %0d want 0 0", resp_seen, stall_seen);
    else passed++;
    checks++;
    if ((rd_cnt - r0) !== 1 || (wr_cnt - w0) !== 0)
      $display("FAIL rst_mid_no_replay got rd %0d wr %0d want 1 0", rd_cnt - r0, wr_cnt - w0);
    else passed++;
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout;
    bit got; logic [31:0] rd; logic err; int st;
    lat = 0;
    run_op(1'b0, 32'h45, 32'h0, got, rd, err, st);
    checks++;
    if (!got || err !== 1'b1 || rd !== 32'd0)
      $display("FAIL timeout_abort got resp %b err %b rdata %h want 1 1 0", got, err, rd);
    else passed++;
    checks++;
    if (st !== 10) $display("FAIL timeout_stall_cycles got %0d want 10", st);
    else passed++;
    lat = 3;
    run_op(1'b0, 32'h45, 32'h0, got, rd, err, st);
    checks++;
    if (!got || err !== 1'b0 || rd !== 32'h123 || st !== 5)
      $display("FAIL timeout_recover got err %b rdata %h stalls %0d want 0 123 5", err, rd, st);
    else passed++;
  endtask

  task automatic test_timeout_tie;
    bit got; logic [31:0] rd; logic err; int st;
    lat = 8;
    run_op(1'b0, 32'h45, 32'h0, got, rd, err, st);
    checks++;
    if (!got || err !== 1'b0 || rd !== 32'h123 || st !== 10)
      $display("FAIL timeout_tie got err %b rdata %h stalls %0d want 0 123 10", err, rd, st);
    else passed++;
  endtask
`endif

  task automatic test_bus_idle;
    checks++;
    if (dirty_cnt !== 0 || both_cnt !== 0)
      $display("FAIL bus_idle got dirty %0d both %0d want 0 0", dirty_cnt, both_cnt);
    else passed++;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_store();
    test_load_back();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
    test_timeout_tie();
`endif
    test_bus_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
